// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 packet router.
package router_pkg;

  localparam int unsigned ROUTER_DW = 8;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned LEN_W     = ROUTER_DW - ADDR_W;

  // Address 3 has no FIFO behind it; such headers are never latched.
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  // Controller states; router_fsm decodes these into the one-hot strobes.
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } router_state_e;

  // Header byte layout: payload length in the upper bits, destination in the low bits.
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } router_hdr_t;

  // True when the header targets one of the three real FIFOs.
  function automatic logic addr_is_valid(input router_hdr_t hdr);
    return hdr.addr != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running packet parity, received parity capture, completion and error flags.
module router_parity_chk
  import router_pkg::*;
#(
  parameter int unsigned DW = ROUTER_DW
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          detect_add,
  input  logic          lfd_state,
  input  logic          ld_state,
  input  logic          laf_state,
  input  logic          pkt_valid,
  input  logic          fifo_full,
  input  logic          low_pkt_valid,
  input  logic [DW-1:0] data_in,
  input  logic [DW-1:0] header_byte,
  output logic          parity_done,
  output logic          err
);

  logic [DW-1:0] int_parity_q, int_parity_d;
  logic [DW-1:0] pkt_parity_q, pkt_parity_d;
  logic          parity_done_q, parity_done_d;
  logic          err_q, err_d;

  // Parity byte is forwarded directly, or released from the hold register after a full stall.
  logic          parity_fwd_c;
  logic          parity_late_c;

  assign parity_fwd_c  = ld_state && !pkt_valid && !fifo_full;
  assign parity_late_c = laf_state && low_pkt_valid && !parity_done_q;

  // Accumulate header and payload; each payload byte counts once, on its LOAD_DATA cycle.
  always_comb begin
    int_parity_d = int_parity_q;
    if (detect_add) begin
      int_parity_d = '0;
    end else if (lfd_state) begin
      int_parity_d = int_parity_q ^ header_byte;
    end else if (ld_state && pkt_valid) begin
      int_parity_d = int_parity_q ^ data_in;
    end
  end

  // Capture the trailing parity byte sent by the source.
  always_comb begin
    pkt_parity_d = pkt_parity_q;
    if (ld_state && !pkt_valid) begin
      pkt_parity_d = data_in;
    end
  end

  // Completion flag; cleared at the start of each packet.
  always_comb begin
    parity_done_d = parity_done_q;
    if (detect_add) begin
      parity_done_d = 1'b0;
    end else if (parity_fwd_c || parity_late_c) begin
      parity_done_d = 1'b1;
    end
  end

  // Compare once both parities are settled; holds until the next packet.
  always_comb begin
    err_d = err_q;
    if (detect_add) begin
      err_d = 1'b0;
    end else if (parity_done_q) begin
      err_d = int_parity_q != pkt_parity_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      int_parity_q  <= '0;
      pkt_parity_q  <= '0;
      parity_done_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      int_parity_q  <= int_parity_d;
      pkt_parity_q  <= pkt_parity_d;
      parity_done_q <= parity_done_d;
      err_q         <= err_d;
    end
  end

  assign parity_done = parity_done_q;
  assign err         = err_q;

endmodule

// File: rtl/router_reg.sv
// Router input register: header latch, registered byte bus to the FIFOs, full-stall hold byte.
module router_reg
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = ROUTER_DW
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              full_state,
  input  logic              laf_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err
);

  logic [DATA_W-1:0] header_byte_q, header_byte_d;
  logic [DATA_W-1:0] hold_byte_q, hold_byte_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              low_pkt_valid_q, low_pkt_valid_d;

  // The source is stalled upstream while the FIFO is full, so nothing here moves then.
  logic              upd_en_c;
  router_hdr_t       hdr_in_c;

  assign upd_en_c = !full_state;
  assign hdr_in_c = router_hdr_t'(data_in);

  // Latch the header only when it addresses a real FIFO.
  always_comb begin
    header_byte_d = header_byte_q;
    if (upd_en_c && detect_add && pkt_valid && addr_is_valid(hdr_in_c)) begin
      header_byte_d = data_in;
    end
  end

  // Byte bus: header first, then live payload, then the byte parked during a full stall.
  always_comb begin
    dout_d = dout_q;
    if (upd_en_c) begin
      if (lfd_state) begin
        dout_d = header_byte_q;
      end else if (ld_state && !fifo_full) begin
        dout_d = data_in;
      end else if (laf_state) begin
        dout_d = hold_byte_q;
      end
    end
  end

  // Park the byte that arrived while the addressed FIFO was full.
  always_comb begin
    hold_byte_d = hold_byte_q;
    if (upd_en_c && ld_state && fifo_full) begin
      hold_byte_d = data_in;
    end
  end

  // Remember that the parity byte has been seen, until the parity check state clears it.
  always_comb begin
    low_pkt_valid_d = low_pkt_valid_q;
    if (upd_en_c) begin
      if (rst_int_reg) begin
        low_pkt_valid_d = 1'b0;
      end else if (ld_state && !pkt_valid) begin
        low_pkt_valid_d = 1'b1;
      end
    end
  end

  // Data path registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      header_byte_q   <= '0;
      hold_byte_q     <= '0;
      dout_q          <= '0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      header_byte_q   <= header_byte_d;
      hold_byte_q     <= hold_byte_d;
      dout_q          <= dout_d;
      low_pkt_valid_q <= low_pkt_valid_d;
    end
  end

  router_parity_chk #(
    .DW (DATA_W)
  ) u_parity_chk (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .pkt_valid     (pkt_valid),
    .fifo_full     (fifo_full),
    .low_pkt_valid (low_pkt_valid_q),
    .data_in       (data_in),
    .header_byte   (header_byte_q),
    .parity_done   (parity_done),
    .err           (err)
  );

  assign dout          = dout_q;
  assign low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: packet sequences with hand-computed expectations.
module tb_router_reg;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_pkt_valid, err;

  int n_checks = 0;
  int n_fail   = 0;

  router_reg #(.DATA_W(8)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .full_state    (full_state),
    .laf_state     (laf_state),
    .rst_int_reg   (rst_int_reg),
    .dout          (dout),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err)
  );

  always #5 clock = ~clock;

  // Drive one cycle of FSM strobes and source data, then sample 1 time unit after the edge.
  task automatic step(input router_state_e st, input logic pv, input logic [7:0] din,
                      input logic full);
    detect_add  = (st == DECODE_ADDRESS);
    lfd_state   = (st == LOAD_FIRST_DATA);
    ld_state    = (st == LOAD_DATA);
    full_state  = (st == FIFO_FULL_STATE);
    laf_state   = (st == LOAD_AFTER_FULL);
    rst_int_reg = (st == CHECK_PARITY_ERROR);
    pkt_valid   = pv;
    data_in     = din;
    fifo_full   = full;
    @(posedge clock);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    step(WAIT_TILL_EMPTY, 1'b0, 8'h00, 1'b0);
    step(WAIT_TILL_EMPTY, 1'b0, 8'h00, 1'b0);
    chk8("rst_dout", dout, 8'h00);
    chk1("rst_parity_done", parity_done, 1'b0);
    chk1("rst_low_pkt_valid", low_pkt_valid, 1'b0);
    chk1("rst_err", err, 1'b0);
    resetn = 1'b1;

    // Good packet: 0D ^ 11 ^ 22 ^ 33 = 0D matches the parity byte.
    step(DECODE_ADDRESS, 1'b1, 8'h0D, 1'b0);
    step(LOAD_FIRST_DATA, 1'b1, 8'h11, 1'b0);
    chk8("good_hdr", dout, 8'h0D);
    step(LOAD_DATA, 1'b1, 8'h11, 1'b0);
    chk8("good_p0", dout, 8'h11);
    step(LOAD_DATA, 1'b1, 8'h22, 1'b0);
    chk8("good_p1", dout, 8'h22);
    step(LOAD_DATA, 1'b1, 8'h33, 1'b0);
    chk8("good_p2", dout, 8'h33);
    chk1("good_pd_before", parity_done, 1'b0);
    step(LOAD_DATA, 1'b0, 8'h0D, 1'b0);
    chk8("good_par_byte", dout, 8'h0D);
    chk1("good_pd", parity_done, 1'b1);
    chk1("good_low", low_pkt_valid, 1'b1);
    step(LOAD_PARITY, 1'b0, 8'h00, 1'b0);
    chk1("good_err", err, 1'b0);
    step(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
    chk1("good_low_clr", low_pkt_valid, 1'b0);

    // Bad parity: same packet, parity byte FF.
    step(DECODE_ADDRESS, 1'b1, 8'h0D, 1'b0);
    chk1("bad_pd_clr", parity_done, 1'b0);
    step(LOAD_FIRST_DATA, 1'b1, 8'h11, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h11, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h22, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h33, 1'b0);
    step(LOAD_DATA, 1'b0, 8'hFF, 1'b0);
    chk8("bad_par_byte", dout, 8'hFF);
    chk1("bad_pd", parity_done, 1'b1);
    chk1("bad_err_not_yet", err, 1'b0);
    step(LOAD_PARITY, 1'b0, 8'h00, 1'b0);
    chk1("bad_err", err, 1'b1);
    step(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
    chk1("bad_err_hold", err, 1'b1);

    // Invalid address: 0F is not latched, the previous header 0E is replayed.
    step(DECODE_ADDRESS, 1'b1, 8'h0E, 1'b0);
    chk1("bad_err_clr", err, 1'b0);
    step(DECODE_ADDRESS, 1'b1, 8'h0F, 1'b0);
    step(LOAD_FIRST_DATA, 1'b1, 8'h0F, 1'b0);
    chk8("inv_old_hdr", dout, 8'h0E);
    step(LOAD_DATA, 1'b0, 8'h0E, 1'b0);
    chk1("inv_pd", parity_done, 1'b1);
    step(LOAD_PARITY, 1'b0, 8'h00, 1'b0);
    chk1("inv_err", err, 1'b0);
    step(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);

    // FIFO full mid-payload: 22 is held, released in LOAD_AFTER_FULL, counted once.
    step(DECODE_ADDRESS, 1'b1, 8'h0D, 1'b0);
    step(LOAD_FIRST_DATA, 1'b1, 8'h11, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h11, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h22, 1'b1);
    chk8("full_dout_hold", dout, 8'h11);
    step(FIFO_FULL_STATE, 1'b1, 8'h99, 1'b1);
    chk8("full_state_hold", dout, 8'h11);
    step(LOAD_AFTER_FULL, 1'b1, 8'h99, 1'b0);
    chk8("full_release", dout, 8'h22);
    chk1("full_pd_not_set", parity_done, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h33, 1'b0);
    chk8("full_p2", dout, 8'h33);
    step(LOAD_DATA, 1'b0, 8'h0D, 1'b0);
    chk1("full_pd", parity_done, 1'b1);
    step(LOAD_PARITY, 1'b0, 8'h00, 1'b0);
    chk1("full_err", err, 1'b0);
    step(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
    chk1("full_low_clr", low_pkt_valid, 1'b0);

    // Parity byte arrives while the FIFO is full.
    step(DECODE_ADDRESS, 1'b1, 8'h0D, 1'b0);
    step(LOAD_FIRST_DATA, 1'b1, 8'h11, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h11, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h22, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h33, 1'b0);
    step(LOAD_DATA, 1'b0, 8'h0D, 1'b1);
    chk1("pfull_low", low_pkt_valid, 1'b1);
    chk1("pfull_pd_wait", parity_done, 1'b0);
    chk8("pfull_dout_hold", dout, 8'h33);
    step(FIFO_FULL_STATE, 1'b0, 8'h00, 1'b1);
    chk1("pfull_pd_still", parity_done, 1'b0);
    step(LOAD_AFTER_FULL, 1'b0, 8'h00, 1'b0);
    chk8("pfull_par_out", dout, 8'h0D);
    chk1("pfull_pd", parity_done, 1'b1);
    step(LOAD_PARITY, 1'b0, 8'h00, 1'b0);
    chk1("pfull_err", err, 1'b0);
    step(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
    chk1("pfull_low_clr", low_pkt_valid, 1'b0);

    // Reset mid-packet after two payload bytes.
    step(DECODE_ADDRESS, 1'b1, 8'h0D, 1'b0);
    step(LOAD_FIRST_DATA, 1'b1, 8'h11, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h11, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h22, 1'b0);
    chk8("mid_before_rst", dout, 8'h22);
    resetn = 1'b0;
    step(LOAD_DATA, 1'b1, 8'h33, 1'b0);
    chk8("mid_rst_dout", dout, 8'h00);
    chk1("mid_rst_err", err, 1'b0);
    chk1("mid_rst_pd", parity_done, 1'b0);
    chk1("mid_rst_low", low_pkt_valid, 1'b0);
    resetn = 1'b1;
    // Header register was cleared: an unlatched header replays 00.
    step(DECODE_ADDRESS, 1'b1, 8'h0F, 1'b0);
    step(LOAD_FIRST_DATA, 1'b1, 8'h00, 1'b0);
    chk8("mid_hdr_cleared", dout, 8'h00);

    // Clean packet after reset.
    step(DECODE_ADDRESS, 1'b1, 8'h0D, 1'b0);
    step(LOAD_FIRST_DATA, 1'b1, 8'h11, 1'b0);
    chk8("post_hdr", dout, 8'h0D);
    step(LOAD_DATA, 1'b1, 8'h11, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h22, 1'b0);
    step(LOAD_DATA, 1'b1, 8'h33, 1'b0);
    chk8("post_p2", dout, 8'h33);
    step(LOAD_DATA, 1'b0, 8'h0D, 1'b0);
    chk1("post_pd", parity_done, 1'b1);
    step(LOAD_PARITY, 1'b0, 8'h00, 1'b0);
    chk1("post_err", err, 1'b0);
    step(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_reg.md
# router_reg

Input register stage of the 1x3 packet router. It sits between the packet source and the three router_fifo instances. It latches the header byte, streams header and payload onto a registered byte bus that feeds every FIFO's data_in, and holds one byte while the selected FIFO is full. It also accumulates packet parity and flags a mismatch, driven entirely by state-decode strobes from router_fsm.

## Interface
Parameters:
- DATA_W, 8, byte width of data_in/dout (fixed at 8 by packet format)

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- pkt_valid  in  1  high for header+payload bytes, low on parity byte
- data_in  in  8  source byte; header = {len[7:2], addr[1:0]}
- fifo_full  in  1  full of currently addressed FIFO (from router_sync)
- detect_add  in  1  FSM in DECODE_ADDRESS
- lfd_state  in  1  FSM in LOAD_FIRST_DATA
- ld_state  in  1  FSM in LOAD_DATA
- full_state  in  1  FSM in FIFO_FULL_STATE
- laf_state  in  1  FSM in LOAD_AFTER_FULL
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR
- dout  out  8  byte to FIFO data_in
- parity_done  out  1  parity byte has been forwarded
- low_pkt_valid  out  1  pkt_valid dropped while loading (parity byte seen)
- err  out  1  parity mismatch for the completed packet

## Operation
Internal registers: header_byte, hold_byte, int_parity, pkt_parity (all 8 b, reset 0).
- Header capture: detect_add && pkt_valid && data_in[1:0]!=2'b11 -> header_byte <= data_in. Address 3 is never latched.
- dout priority (one per cycle): lfd_state -> header_byte; ld_state && !fifo_full -> data_in; laf_state -> hold_byte; else hold.
- ld_state && fifo_full -> hold_byte <= data_in, dout unchanged.
- int_parity: detect_add -> 0; lfd_state -> ^= header_byte; ld_state && pkt_valid -> ^= data_in. Each payload byte is counted exactly once, whether forwarded or held.
- pkt_parity: ld_state && !pkt_valid -> data_in.
- low_pkt_valid: rst_int_reg -> 0; ld_state && !pkt_valid -> 1; else hold.
- parity_done: detect_add -> 0; (ld_state && !pkt_valid && !fifo_full) or (laf_state && low_pkt_valid && !parity_done) -> 1; else hold.
- err: detect_add -> 0; parity_done -> (int_parity != pkt_parity); else hold.
- full_state: no register updates. The source is stalled upstream by busy.
- Strobes are one-hot from the FSM. Behaviour under multiple simultaneous strobes is undefined; verification asserts one-hot.

## Timing
- All outputs are registered. Reset values: dout=0, parity_done=0, low_pkt_valid=0, err=0; internal registers are also 0.
- resetn low wins over every strobe at the same edge. Reset mid-packet discards all state. The next packet starts clean from DECODE_ADDRESS.
- dout latency is 1 cycle from the qualifying strobe edge.
- parity_done rises 1 cycle after the parity byte is forwarded.
- err is valid from 1 cycle after parity_done rises and holds until the next detect_add.
- A byte held during fifo_full appears on dout 1 cycle after laf_state.

## Structure
- Shared package router_pkg holds:
  - ROUTER_DW = 8
  - ADDR_INVALID = 2'b11
  - the FSM state enum, also used by router_fsm
- Sub-module router_parity_chk holds int_parity, pkt_parity, parity_done and err. Inputs are the strobes, data_in, header_byte, pkt_valid, fifo_full and low_pkt_valid.
- The data path, header capture and hold register stay in the top module.

## Test plan
- Good packet: header 8'h0D (len 3, addr 1), payload 8'h11, 8'h22, 8'h33, parity 8'h0D -> dout sequence 0D,11,22,33,0D; parity_done=1; then err=0.
- Bad parity: same packet with parity 8'hFF -> err=1 one cycle after parity_done. err clears on the next detect_add.
- Invalid address: detect_add with data_in=8'h0F -> header_byte stays at its previous value. A subsequent lfd_state drives the old header.
- FIFO full mid-payload: fifo_full=1 during ld_state with data_in=8'h22 -> dout holds 8'h11. After full_state then laf_state, dout=8'h22. int_parity includes 22 exactly once; err=0.
- Parity byte arrives while full: ld_state, pkt_valid=0, fifo_full=1 -> low_pkt_valid=1, parity_done stays 0. In laf_state, parity_done=1 and dout=parity byte. rst_int_reg clears low_pkt_valid.
- Reset mid-packet: resetn low during ld_state after 2 payload bytes -> dout=0, err=0, parity_done=0, low_pkt_valid=0. The next good packet passes with err=0.
